alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU32Bit interface. Accepts one decoded MIPS op per valid/ready handshake.

---
 rtl/alu_pkg.sv | 76 +++++++
 rtl/alu_issue_decode.sv | 68 ++++++
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, MIPS opcode/funct
// encodings, operand-select codes, op classes and FSM states. Optional MADD_EN adds ACCUM.
package alu_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_MUL = 5'd2;
  localparam logic [4:0] ALU_GEZ = 5'd3;
  localparam logic [4:0] ALU_LEZ = 5'd5;
  localparam logic [4:0] ALU_AND = 5'd8;
  localparam logic [4:0] ALU_OR  = 5'd9;
  localparam logic [4:0] ALU_NOR = 5'd10;
  localparam logic [4:0] ALU_XOR = 5'd11;
  localparam logic [4:0] ALU_SLL = 5'd12;
  localparam logic [4:0] ALU_SRL = 5'd13;
  localparam logic [4:0] ALU_SLT = 5'd14;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_MADD = 6'h00;
  localparam logic [5:0] FN_MUL  = 6'h02;
  localparam logic [5:0] FN_MSUB = 6'h04;

  localparam logic [1:0] BSEL_RT    = 2'd0;
  localparam logic [1:0] BSEL_SHAMT = 2'd1;
  localparam logic [1:0] BSEL_SEXT  = 2'd2;
  localparam logic [1:0] BSEL_ZEXT  = 2'd3;

  // Classes with bit 3 clear issue to the ALU; bit 3 set completes without the ALU.
  localparam logic [3:0] CLS_ALU   = 4'd0;
  localparam logic [3:0] CLS_MULT  = 4'd1;
  localparam logic [3:0] CLS_BR_Z  = 4'd2;
  localparam logic [3:0] CLS_BR_NZ = 4'd3;
  localparam logic [3:0] CLS_BR_R0 = 4'd4;
  localparam logic [3:0] CLS_MADD  = 4'd5;
  localparam logic [3:0] CLS_MSUB  = 4'd6;
  localparam logic [3:0] CLS_MFHI  = 4'd8;
  localparam logic [3:0] CLS_MFLO  = 4'd9;
  localparam logic [3:0] CLS_MTHI  = 4'd10;
  localparam logic [3:0] CLS_MTLO  = 4'd11;
  localparam logic [3:0] CLS_ILL   = 4'd15;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
`ifdef MADD_EN
  localparam logic [1:0] ST_ACCUM = 2'd2;
`endif
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of Opcode/Funct/RtField into ALU op, operand selects and op class.
// madd/msub decode only when MADD_EN is defined; otherwise they fall through to illegal.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt_field,
  output logic [4:0] alu_ctrl,
  output logic       a_sel_rt,
  output logic [1:0] b_sel,
  output logic [3:0] op_class
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    a_sel_rt = 1'b0;
    b_sel    = BSEL_RT;
    op_class = CLS_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: begin alu_ctrl = ALU_ADD; op_class = CLS_ALU; end
          FN_SUB:  begin alu_ctrl = ALU_SUB; op_class = CLS_ALU; end
          FN_AND:  begin alu_ctrl = ALU_AND; op_class = CLS_ALU; end
          FN_OR:   begin alu_ctrl = ALU_OR;  op_class = CLS_ALU; end
          FN_XOR:  begin alu_ctrl = ALU_XOR; op_class = CLS_ALU; end
          FN_NOR:  begin alu_ctrl = ALU_NOR; op_class = CLS_ALU; end
          FN_SLT:  begin alu_ctrl = ALU_SLT; op_class = CLS_ALU; end
          FN_SLL:  begin alu_ctrl = ALU_SLL; a_sel_rt = 1'b1; b_sel = BSEL_SHAMT; op_class = CLS_ALU; end
          FN_SRL:  begin alu_ctrl = ALU_SRL; a_sel_rt = 1'b1; b_sel = BSEL_SHAMT; op_class = CLS_ALU; end
          FN_MULT: begin alu_ctrl = ALU_MUL; op_class = CLS_MULT; end
          FN_MFHI: op_class = CLS_MFHI;
          FN_MFLO: op_class = CLS_MFLO;
          FN_MTHI: op_class = CLS_MTHI;
          FN_MTLO: op_class = CLS_MTLO;
          default: op_class = CLS_ILL;
        endcase
      end
      OP_REGIMM: begin
        if (rt_field == 5'd1) begin
          alu_ctrl = ALU_GEZ;
          op_class = CLS_BR_R0;
        end
      end
      OP_BEQ:   begin alu_ctrl = ALU_SUB; op_class = CLS_BR_Z;  end
      OP_BNE:   begin alu_ctrl = ALU_SUB; op_class = CLS_BR_NZ; end
      OP_BLEZ:  begin alu_ctrl = ALU_LEZ; op_class = CLS_BR_R0; end
      OP_ADDI, OP_ADDIU: begin alu_ctrl = ALU_ADD; b_sel = BSEL_SEXT; op_class = CLS_ALU; end
      OP_SLTI:  begin alu_ctrl = ALU_SLT; b_sel = BSEL_SEXT; op_class = CLS_ALU; end
      OP_ANDI:  begin alu_ctrl = ALU_AND; b_sel = BSEL_ZEXT; op_class = CLS_ALU; end
      OP_ORI:   begin alu_ctrl = ALU_OR;  b_sel = BSEL_ZEXT; op_class = CLS_ALU; end
      OP_XORI:  begin alu_ctrl = ALU_XOR; b_sel = BSEL_ZEXT; op_class = CLS_ALU; end
      OP_SPECIAL2: begin
        case (funct)
          FN_MUL:  begin alu_ctrl = ALU_MUL; op_class = CLS_ALU; end
`ifdef MADD_EN
          FN_MADD: begin alu_ctrl = ALU_MUL; op_class = CLS_MADD; end
          FN_MSUB: begin alu_ctrl = ALU_MUL; op_class = CLS_MSUB; end
`endif
          default: op_class = CLS_ILL;
        endcase
      end
      default: op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU32Bit initiator: accepts decoded ops (valid/ready), drives the ALU, captures results,
// owns HI/LO and returns results on an output valid/ready port. MADD_EN adds madd/msub.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [4:0]  RtField,
  input  logic [4:0]  Shamt,
  input  logic [15:0] Imm,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  output logic [4:0]  ALUControl,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ALUResultHi,
  input  logic        Zero,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Result,
  output logic        BranchTaken,
  output logic        Illegal,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload stay stable until that edge, ready may change freely.
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cls_q;
  logic [4:0]       dec_alu;
  logic             dec_a_rt;
  logic [1:0]       dec_bsel;
  logic [3:0]       dec_class;
  logic [31:0]      a_next;
  logic [31:0]      b_next;
  logic             br_next;
`ifdef MADD_EN
  logic [63:0]      prod;
`endif

  alu_issue_decode u_decode (
    .opcode   (Opcode),
    .funct    (Funct),
    .rt_field (RtField),
    .alu_ctrl (dec_alu),
    .a_sel_rt (dec_a_rt),
    .b_sel    (dec_bsel),
    .op_class (dec_class)
  );

  assign InReady   = (state == ST_IDLE) && !Reset;
  assign OutValid  = (state == ST_DONE);
  assign dbg_state = state;
  assign a_next    = dec_a_rt ? RtData : RsData;

  always_comb begin
    b_next = RtData;
    case (dec_bsel)
      BSEL_SHAMT: b_next = {27'b0, Shamt};
      BSEL_SEXT:  b_next = {{16{Imm[15]}}, Imm};
      BSEL_ZEXT:  b_next = {16'b0, Imm};
      default:    b_next = RtData;
    endcase
  end

  always_comb begin
    br_next = 1'b0;
    case (cls_q)
      CLS_BR_Z:  br_next = Zero;
      CLS_BR_NZ: br_next = ~Zero;
      CLS_BR_R0: br_next = ALUResult[0];
      default:   br_next = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cls_q       <= '0;
      ALUControl  <= '0;
      A           <= '0;
      B           <= '0;
      Result      <= '0;
      BranchTaken <= 1'b0;
      Illegal     <= 1'b0;
      Hi          <= '0;
      Lo          <= '0;
`ifdef MADD_EN
      prod        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (InValid) begin
            cls_q <= dec_class;
            if (!dec_class[3]) begin
              ALUControl <= dec_alu;
              A          <= a_next;
              B          <= b_next;
              cnt        <= CNT_W'(1);
              state      <= ST_WAIT;
            end else begin
              BranchTaken <= 1'b0;
              Illegal     <= (dec_class == CLS_ILL);
              Result      <= (dec_class == CLS_MFHI) ? Hi :
                             (dec_class == CLS_MFLO) ? Lo : 32'd0;
              if (dec_class == CLS_MTHI) Hi <= RsData;
              if (dec_class == CLS_MTLO) Lo <= RsData;
              state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(SETTLE_CYCLES)) begin
            Illegal     <= 1'b0;
            BranchTaken <= br_next;
            Result      <= (cls_q == CLS_ALU) ? ALUResult : 32'd0;
            if (cls_q == CLS_MULT) {Hi, Lo} <= {ALUResultHi, ALUResult};
`ifdef MADD_EN
            if (cls_q == CLS_MADD || cls_q == CLS_MSUB) begin
              prod  <= {ALUResultHi, ALUResult};
              state <= ST_ACCUM;
            end else begin
              state <= ST_DONE;
            end
`else
            state <= ST_DONE;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef MADD_EN
        ST_ACCUM: begin
          {Hi, Lo} <= (cls_q == CLS_MSUB) ? ({Hi, Lo} - prod) : ({Hi, Lo} + prod);
          state    <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (OutReady) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU stand-in and a result scoreboard.
// Build with MADD_EN defined to cover madd/msub; otherwise they are checked as illegal.
module tb_alu_issue_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [5:0]  Opcode = '0;
  logic [5:0]  Funct = '0;
  logic [4:0]  RtField = '0;
  logic [4:0]  Shamt = '0;
  logic [15:0] Imm = '0;
  logic [31:0] RsData = '0;
  logic [31:0] RtData = '0;
  logic [4:0]  ALUControl;
  logic [31:0] A, B;
  logic [31:0] ALUResult, ALUResultHi;
  logic        Zero;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] Result;
  logic        BranchTaken, Illegal;
  logic [31:0] Hi, Lo;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .Funct(Funct), .RtField(RtField), .Shamt(Shamt), .Imm(Imm),
    .RsData(RsData), .RtData(RtData), .ALUControl(ALUControl), .A(A), .B(B),
    .ALUResult(ALUResult), .ALUResultHi(ALUResultHi), .Zero(Zero),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .BranchTaken(BranchTaken), .Illegal(Illegal), .Hi(Hi), .Lo(Lo),
    .dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  // Behavioural ALU32Bit stand-in.
  logic [63:0] alu_prod;
  always_comb begin
    alu_prod    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    ALUResultHi = 32'd0;
    case (ALUControl)
      5'd0:  ALUResult = A + B;
      5'd1:  ALUResult = A - B;
      5'd2:  begin ALUResult = alu_prod[31:0]; ALUResultHi = alu_prod[63:32]; end
      5'd3:  ALUResult = {31'd0, ~A[31]};
      5'd5:  ALUResult = {31'd0, A[31] || (A == 32'd0)};
      5'd8:  ALUResult = A & B;
      5'd9:  ALUResult = A | B;
      5'd10: ALUResult = ~(A | B);
      5'd11: ALUResult = A ^ B;
      5'd12: ALUResult = A << B[4:0];
      5'd13: ALUResult = A >> B[4:0];
      5'd14: ALUResult = {31'd0, $signed(A) < $signed(B)};
      default: ALUResult = 32'd0;
    endcase
    Zero = (ALUResult == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_r(input logic [5:0] fn, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [4:0] sh);
    case (fn)
      6'h20, 6'h21: return rs + rt;
      6'h22: return rs - rt;
      6'h24: return rs & rt;
      6'h25: return rs | rt;
      6'h26: return rs ^ rt;
      6'h27: return ~(rs | rt);
      6'h2A: return ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
      6'h00: return rt << sh;
      6'h02: return rt >> sh;
      default: return 32'd0;
    endcase
  endfunction

  // Drives one op and returns 1 ns after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                       input logic [4:0] sh, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rtd);
    int n = 0;
    @(negedge Clk);
    while (!InReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("in_ready_wait", 64'(InReady), 64'h1);
    Opcode = op; Funct = fn; RtField = rt; Shamt = sh; Imm = imm;
    RsData = rs; RtData = rtd; InValid = 1'b1;
    @(posedge Clk);
    #1 InValid = 1'b0;
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int lat = 1;
    logic [33:0] exp;
    while (!OutValid && lat < 30) begin
      @(posedge Clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk({tag, "_result"}, 64'({Result, BranchTaken, Illegal}), 64'(exp));
    end else begin
      chk({tag, "_queue_empty"}, 64'h1, 64'h0);
    end
  endtask

  task automatic release_out();
    OutReady = 1'b1;
    @(posedge Clk);
    #1 OutReady = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rt, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [31:0] rs, input logic [31:0] rtd,
                        input logic [31:0] res, input logic br, input logic ill, input int lat);
    exp_q.push_back({res, br, ill});
    issue(op, fn, rt, sh, imm, rs, rtd);
    collect(tag, lat);
    release_out();
  endtask

  initial begin
    logic [5:0] fns[10];
    logic [31:0] rs, rt;
    logic [4:0] sh;
    fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_in_ready", 64'(InReady), 64'h0);
    chk("rst_out_valid", 64'(OutValid), 64'h0);
    chk("rst_result", 64'(Result), 64'h0);
    chk("rst_hilo", 64'({Hi, Lo}), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'h0);
    @(negedge Clk) Reset = 1'b0;
    #1 chk("idle_in_ready", 64'(InReady), 64'h1);

    // addi with sign-extended immediate
    exp_q.push_back({32'd4, 1'b0, 1'b0});
    issue(6'h08, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'd5, 32'd0);
    chk("addi_b", 64'(B), 64'hFFFF_FFFF);
    chk("addi_ctrl", 64'(ALUControl), 64'h0);
    chk("addi_state", 64'(dbg_state), 64'h1);
    collect("addi", 2);
    release_out();

    // mult then mfhi/mflo
    run_op("mult", 6'h00, 6'h18, 5'd0, 5'd0, 16'h0, 32'h10000, 32'h10000, 32'd0, 1'b0, 1'b0, 2);
    chk("mult_hilo", 64'({Hi, Lo}), 64'h1_0000_0000);
    run_op("mfhi", 6'h00, 6'h10, 5'd0, 5'd0, 16'h0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1);
    run_op("mflo", 6'h00, 6'h12, 5'd0, 5'd0, 16'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    run_op("mult_neg", 6'h00, 6'h18, 5'd0, 5'd0, 16'h0, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 1'b0, 2);
    chk("mult_neg_hilo", 64'({Hi, Lo}), 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("mul", 6'h1C, 6'h02, 5'd0, 5'd0, 16'h0, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 2);
    chk("mul_hilo_kept", 64'({Hi, Lo}), 64'hFFFF_FFFF_FFFF_FFFA);

    // Branches
    run_op("beq_eq", 6'h04, 6'h00, 5'd0, 5'd0, 16'h0, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 2);
    run_op("bne_eq", 6'h05, 6'h00, 5'd0, 5'd0, 16'h0, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0, 2);
    run_op("bne_ne", 6'h05, 6'h00, 5'd0, 5'd0, 16'h0, 32'd7, 32'd8, 32'd0, 1'b1, 1'b0, 2);
    run_op("bgez_0", 6'h01, 6'h00, 5'd1, 5'd0, 16'h0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 2);
    run_op("bgez_neg", 6'h01, 6'h00, 5'd1, 5'd0, 16'h0, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 2);
    run_op("blez_pos", 6'h06, 6'h00, 5'd0, 5'd0, 16'h0, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 2);
    run_op("blez_min", 6'h06, 6'h00, 5'd0, 5'd0, 16'h0, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 2);

    // Immediates: zero vs sign extension
    run_op("andi", 6'h0C, 6'h00, 5'd0, 5'd0, 16'h8001, 32'hFFFF_0000, 32'd0, 32'd0, 1'b0, 1'b0, 2);
    run_op("ori", 6'h0D, 6'h00, 5'd0, 5'd0, 16'h8001, 32'hFFFF_0000, 32'd0, 32'hFFFF_8001, 1'b0, 1'b0, 2);
    run_op("xori", 6'h0E, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'h0000_00FF, 32'd0, 32'h0000_FF00, 1'b0, 1'b0, 2);
    run_op("slti", 6'h0A, 6'h00, 5'd0, 5'd0, 16'hFFFF, 32'hFFFF_FFFE, 32'd0, 32'd1, 1'b0, 1'b0, 2);
    run_op("addiu_wrap", 6'h09, 6'h00, 5'd0, 5'd0, 16'h0001, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 2);

    // R-type table with random operands
    foreach (fns[i]) begin
      rs = $urandom;
      rt = $urandom;
      sh = 5'($urandom_range(0, 31));
      run_op($sformatf("rtype_fn%0h", fns[i]), 6'h00, fns[i], 5'd0, sh, 16'h0, rs, rt,
             ref_r(fns[i], rs, rt, sh), 1'b0, 1'b0, 2);
    end

    // Back-pressure: result held, no second accept
    exp_q.push_back({32'd101, 1'b0, 1'b0});
    issue(6'h08, 6'h00, 5'd0, 5'd0, 16'h0001, 32'd100, 32'd0);
    collect("hold", 2);
    Opcode = 6'h08; Imm = 16'h0055; RsData = 32'd0; InValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk);
      #1;
      chk("hold_out_valid", 64'(OutValid), 64'h1);
      chk("hold_result", 64'(Result), 64'd101);
      chk("hold_in_ready", 64'(InReady), 64'h0);
    end
    release_out();
    InValid = 1'b0;
    @(posedge Clk);
    #1;
    chk("hold_no_accept_state", 64'(dbg_state), 64'h0);
    chk("hold_no_accept_valid", 64'(OutValid), 64'h0);

    // Reset in the middle of WAIT
    run_op("mthi", 6'h00, 6'h11, 5'd0, 5'd0, 16'h0, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    run_op("mfhi2", 6'h00, 6'h10, 5'd0, 5'd0, 16'h0, 32'd0, 32'd0, 32'h1234, 1'b0, 1'b0, 1);
    issue(6'h08, 6'h00, 5'd0, 5'd0, 16'h0009, 32'd9, 32'd0);
    chk("mid_wait_state", 64'(dbg_state), 64'h1);
    #1 Reset = 1'b1;
    #1;
    chk("arst_result", 64'(Result), 64'h0);
    chk("arst_hilo", 64'({Hi, Lo}), 64'h0);
    chk("arst_state", 64'(dbg_state), 64'h0);
    chk("arst_a", 64'(A), 64'h0);
    chk("arst_out_valid", 64'(OutValid), 64'h0);
    @(negedge Clk) Reset = 1'b0;
    run_op("after_rst", 6'h08, 6'h00, 5'd0, 5'd0, 16'h0002, 32'd1, 32'd0, 32'd3, 1'b0, 1'b0, 2);

    // Illegal encodings leave HI/LO alone
    run_op("mthi3", 6'h00, 6'h11, 5'd0, 5'd0, 16'h0, 32'hCAFE, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    run_op("mtlo3", 6'h00, 6'h13, 5'd0, 5'd0, 16'h0, 32'hBEEF, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    run_op("ill_3f", 6'h3F, 6'h00, 5'd0, 5'd0, 16'h0, 32'h5, 32'h6, 32'd0, 1'b0, 1'b1, 1);
    chk("ill_hilo", 64'({Hi, Lo}), 64'h0000_CAFE_0000_BEEF);
    run_op("ill_subu", 6'h00, 6'h23, 5'd0, 5'd0, 16'h0, 32'h5, 32'h6, 32'd0, 1'b0, 1'b1, 1);
    run_op("ill_regimm", 6'h01, 6'h00, 5'd0, 5'd0, 16'h0, 32'h5, 32'h6, 32'd0, 1'b0, 1'b1, 1);

    // Multiply-accumulate
    run_op("mthi0", 6'h00, 6'h11, 5'd0, 5'd0, 16'h0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1);
    run_op("mtlo5", 6'h00, 6'h13, 5'd0, 5'd0, 16'h0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1);
`ifdef MADD_EN
    run_op("madd", 6'h1C, 6'h00, 5'd0, 5'd0, 16'h0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 3);
    chk("madd_hilo", 64'({Hi, Lo}), 64'd11);
    run_op("msub", 6'h1C, 6'h04, 5'd0, 5'd0, 16'h0, 32'd4, 32'd4, 32'd0, 1'b0, 1'b0, 3);
    chk("msub_hilo", 64'({Hi, Lo}), 64'hFFFF_FFFF_FFFF_FFFB);
`else
    run_op("madd_ill", 6'h1C, 6'h00, 5'd0, 5'd0, 16'h0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1);
    run_op("msub_ill", 6'h1C, 6'h04, 5'd0, 5'd0, 16'h0, 32'd2, 32'd3, 32'd0, 1'b0, 1'b1, 1);
    chk("madd_ill_hilo", 64'({Hi, Lo}), 64'd5);
`endif

    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
